gpio_ctrl: RTL and testbench

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_pkg.sv | 29 ++
 rtl/gpio_sync.sv | 25 ++
 rtl/gpio_ctrl.sv | 132 +++++++++++++
 tb/tb_gpio_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register map and byte-lane helpers.
package gpio_pkg;

  typedef enum logic [2:0] {
    REG_OUT      = 3'd0,
    REG_DIR      = 3'd1,
    REG_IN       = 3'd2,
    REG_SET      = 3'd3,
    REG_CLR      = 3'd4,
    REG_TGL      = 3'd5,
    REG_IRQ_EN   = 3'd6,
    REG_IRQ_STAT = 3'd7
  } gpio_reg_e;

  localparam logic [4:0] OFS_OUT      = 5'h00;
  localparam logic [4:0] OFS_DIR      = 5'h04;
  localparam logic [4:0] OFS_IN       = 5'h08;
  localparam logic [4:0] OFS_SET      = 5'h0C;
  localparam logic [4:0] OFS_CLR      = 5'h10;
  localparam logic [4:0] OFS_TGL      = 5'h14;
  localparam logic [4:0] OFS_IRQ_EN   = 5'h18;
  localparam logic [4:0] OFS_IRQ_STAT = 5'h1C;

  // Byte-lane enable that governs a given data bit.
  function automatic logic strobe_bit(input logic [3:0] strb, input logic [4:0] bit_idx);
    return strb[bit_idx[4:3]];
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer for the asynchronous pin inputs.
module gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO block: output/direction registers, set/clear/toggle
// aliases, synchronized inputs and rising-edge interrupts with W1C status.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      data_in,
  input  logic             rd_strobe,
  input  logic [3:0]       wr_strobe,
  output logic [31:0]      data_out,
  output logic             ack,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] en_q, en_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] prev_q;
  logic             first_q;
  logic [31:0]      data_out_q;
  logic             ack_q;
  logic             irq_q;

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] edge_w;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_val;
  logic             hit, rd_hit, wr_hit;
  gpio_reg_e        reg_idx;
  logic             unused_ok;

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(gpio_i),
    .sync_o (sync_w)
  );

  assign hit     = (addr[31:5] == BASE_ADDR[31:5]);
  assign rd_hit  = hit & rd_strobe;
  assign wr_hit  = hit & (|wr_strobe);
  assign reg_idx = gpio_reg_e'(addr[4:2]);

  // The first sample after reset has no valid predecessor.
  assign edge_w  = sync_w & ~prev_q & {WIDTH{~first_q}};

  always_comb begin
    wmask = '0;
    for (int i = 0; i < WIDTH; i++) wmask[i] = strobe_bit(wr_strobe, i[4:0]);
  end

  assign wdata = data_in[WIDTH-1:0] & wmask;

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_OUT:      rd_val[WIDTH-1:0] = out_q;
      REG_DIR:      rd_val[WIDTH-1:0] = dir_q;
      REG_IN:       rd_val[WIDTH-1:0] = sync_w;
      REG_IRQ_EN:   rd_val[WIDTH-1:0] = en_q;
      REG_IRQ_STAT: rd_val[WIDTH-1:0] = stat_q;
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    en_d   = en_q;
    stat_d = stat_q;
    if (wr_hit) begin
      case (reg_idx)
        REG_OUT:      out_d  = (out_q & ~wmask) | wdata;
        REG_DIR:      dir_d  = (dir_q & ~wmask) | wdata;
        REG_SET:      out_d  = out_q | wdata;
        REG_CLR:      out_d  = out_q & ~wdata;
        REG_TGL:      out_d  = out_q ^ wdata;
        REG_IRQ_EN:   en_d   = (en_q & ~wmask) | wdata;
        REG_IRQ_STAT: stat_d = stat_q & ~wdata;
        default:      ;
      endcase
    end
    // A new edge wins over a same-cycle clear.
    stat_d = stat_d | (edge_w & en_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      dir_q      <= '0;
      en_q       <= '0;
      stat_q     <= '0;
      prev_q     <= '0;
      first_q    <= 1'b1;
      data_out_q <= '0;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      stat_q  <= stat_d;
      prev_q  <= sync_w;
      first_q <= 1'b0;
      ack_q   <= rd_hit | wr_hit;
      irq_q   <= |(stat_q & en_q);
      if (rd_hit) data_out_q <= rd_val;
    end
  end

  assign gpio_o    = out_q;
  assign gpio_oe   = dir_q;
  assign data_out  = data_out_q;
  assign ack       = ack_q;
  assign irq       = irq_q;
  assign unused_ok = ^{addr[1:0], data_in};

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed register-map scenarios followed
// by randomized traffic against a behavioural model of the register map.
module tb_gpio_ctrl;

  localparam int          W    = 8;
  localparam int          S    = 2;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] PM   = 32'h0000_00FF;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr;
  logic [31:0]   data_in;
  logic          rd_strobe;
  logic [3:0]    wr_strobe;
  logic [31:0]   data_out;
  logic          ack;
  logic [W-1:0]  gpio_i;
  logic [W-1:0]  gpio_o;
  logic [W-1:0]  gpio_oe;
  logic          irq;

  always #5 clk = ~clk;

  gpio_ctrl #(
    .WIDTH      (W),
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .rd_strobe(rd_strobe),
    .wr_strobe(wr_strobe),
    .data_out (data_out),
    .ack      (ack),
    .gpio_i   (gpio_i),
    .gpio_o   (gpio_o),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state: registers as plain words, synchronizer as a delay queue.
  logic [31:0] m_out, m_dir, m_en, m_stat, m_dout, m_prev;
  logic        m_ack, m_irq, m_first;
  logic [31:0] q_sync [$];
  logic [31:0] g_pins = '0;

  task automatic model_step(input logic r, input logic [31:0] a, input logic [31:0] d,
                            input logic rs, input logic [3:0] ws, input logic [31:0] g);
    logic [31:0] sync, edges, bm, wd, rv, stat_old, en_old;
    logic        hit;
    if (r) begin
      m_out = 0; m_dir = 0; m_en = 0; m_stat = 0; m_dout = 0; m_prev = 0;
      m_ack = 0; m_irq = 0; m_first = 1;
      q_sync = {};
      for (int i = 0; i < S; i++) q_sync.push_back(32'h0);
      return;
    end
    sync  = q_sync[0];
    edges = m_first ? 32'h0 : (sync & ~m_prev);
    hit   = (a[31:5] == BASE[31:5]);
    bm    = 0;
    for (int k = 0; k < 4; k++) if (ws[k]) bm |= (32'hFF << (8 * k));
    bm &= PM;
    wd = d & bm;
    case (a[4:2])
      3'd0:    rv = m_out;
      3'd1:    rv = m_dir;
      3'd2:    rv = sync;
      3'd6:    rv = m_en;
      3'd7:    rv = m_stat;
      default: rv = 0;
    endcase
    stat_old = m_stat;
    en_old   = m_en;
    if (hit && ws != 0) begin
      case (a[4:2])
        3'd0: m_out  = (m_out & ~bm) | wd;
        3'd1: m_dir  = (m_dir & ~bm) | wd;
        3'd3: m_out  = m_out | wd;
        3'd4: m_out  = m_out & ~wd;
        3'd5: m_out  = m_out ^ wd;
        3'd6: m_en   = (m_en & ~bm) | wd;
        3'd7: m_stat = m_stat & ~wd;
        default: ;
      endcase
    end
    m_stat  = m_stat | (edges & en_old);
    m_irq   = ((stat_old & en_old) != 0);
    m_ack   = hit && (rs || ws != 0);
    if (hit && rs) m_dout = rv;
    m_prev  = sync;
    m_first = 0;
    q_sync.push_back(g & PM);
    void'(q_sync.pop_front());
  endtask

  task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] d,
                     input logic rs, input logic [3:0] ws);
    rst = r; addr = a; data_in = d; rd_strobe = rs; wr_strobe = ws;
    gpio_i = g_pins[W-1:0];
    @(posedge clk);
    model_step(r, a, d, rs, ws, g_pins);
    #1;
    chk("ack", {31'b0, ack}, {31'b0, m_ack});
    chk("data_out", data_out, m_dout);
    chk("gpio_o", 32'(gpio_o), m_out);
    chk("gpio_oe", 32'(gpio_oe), m_dir);
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] ws);
    cyc(1'b0, BASE + {27'b0, idx, 2'b00}, d, 1'b0, ws);
  endtask

  task automatic rd(input logic [2:0] idx);
    cyc(1'b0, BASE + {27'b0, idx, 2'b00}, 32'h0, 1'b1, 4'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
  endtask

  initial begin
    // Reset, with an access issued during reset that must be dropped.
    cyc(1'b1, BASE, 32'hFF, 1'b1, 4'hF);
    cyc(1'b1, BASE + 32'h4, 32'hFF, 1'b1, 4'hF);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_oe", 32'(gpio_oe), 32'h0);

    rd(3'd1);
    chk("rd_dir_ack", {31'b0, ack}, 32'h1);
    chk("rd_dir", data_out, 32'h0);
    rd(3'd0);
    chk("rd_out", data_out, 32'h0);
    rd(3'd7);
    chk("rd_stat", data_out, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    wr(3'd0, 32'hA5, 4'b0001);  chk("out_wr", 32'(gpio_o), 32'hA5);
    wr(3'd3, 32'h0A, 4'b0001);  chk("out_set", 32'(gpio_o), 32'hAF);
    wr(3'd4, 32'h81, 4'b0001);  chk("out_clr", 32'(gpio_o), 32'h2E);
    wr(3'd5, 32'hFF, 4'b0001);  chk("out_tgl", 32'(gpio_o), 32'hD1);

    wr(3'd0, 32'hFFFF, 4'b0010);
    chk("out_hi_lane", 32'(gpio_o), 32'hD1);
    rd(3'd0);
    chk("out_readback", data_out, 32'h0000_00D1);

    wr(3'd6, 32'h01, 4'b0001);
    g_pins = 32'h1;
    idle(1); chk("irq_t1", {31'b0, irq}, 32'h0);
    idle(1); chk("irq_t2", {31'b0, irq}, 32'h0);
    idle(1); chk("irq_t3", {31'b0, irq}, 32'h0);
    idle(1); chk("irq_t4", {31'b0, irq}, 32'h1);
    rd(3'd7);
    chk("stat_set", data_out, 32'h1);
    wr(3'd7, 32'h01, 4'b0001);
    idle(1); chk("irq_w1c", {31'b0, irq}, 32'h0);
    g_pins = 32'h3;
    idle(4);
    rd(3'd7);
    chk("stat_masked", data_out, 32'h0);

    g_pins = 32'h2;
    idle(4);
    g_pins = 32'h3;
    idle(2);
    wr(3'd7, 32'h01, 4'b0001);
    rd(3'd7);
    chk("stat_edge_wins", data_out, 32'h1);
    wr(3'd7, 32'h01, 4'b0001);

    cyc(1'b0, BASE + 32'h20, 32'h55, 1'b1, 4'hF);
    chk("undecoded_ack", {31'b0, ack}, 32'h0);
    chk("undecoded_out", 32'(gpio_o), 32'hD1);
    rd(3'd1);
    chk("undecoded_dir", data_out, 32'h0);

    for (int n = 0; n < 800; n++) begin
      logic        r, rs;
      logic [3:0]  ws;
      logic [31:0] a;
      int          sel;
      r = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 15) g_pins = g_pins ^ (32'h1 << $urandom_range(0, W - 1));
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = BASE + 32'h20 + {27'b0, 3'($urandom_range(0, 7)), 2'b00};
      else if (sel == 1) a = $urandom;
      else               a = BASE + {27'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      rs = ($urandom_range(0, 99) < 40);
      ws = ($urandom_range(0, 99) < 40) ? 4'($urandom_range(1, 15)) : 4'h0;
      cyc(r, a, $urandom, rs, ws);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
